// File: rtl/xoodoo_perm_if.sv
// Start/result bundle between the Xoodyak hash controller and the Xoodoo
// permutation core. The controller holds the master side.
interface xoodoo_perm_if;
    logic         enable;
    logic [383:0] state_in;
    logic [383:0] state_out;
    logic         complete;
    logic         busy;

    modport master (
        output enable,
        output state_in,
        input  state_out,
        input  complete,
        input  busy
    );

    modport slave (
        input  enable,
        input  state_in,
        output state_out,
        output complete,
        output busy
    );
endinterface

// File: rtl/xoodoo_perm.sv
// Iterative Xoodoo[n] permutation: one full round per clock on a 384-bit
// working register. The working register is driven straight out as
// state_out, so intermediate rounds are visible while busy is high.
// Planes are handled as 128-bit vectors (lane x at [32x +: 32]), so the
// lane shifts of theta and rho become whole-plane rotations by 32 or 64 bits.
module xoodoo_perm #(
    parameter int ROUNDS = 12
) (
    input  logic         clk,
    input  logic         resetn,
    xoodoo_perm_if.slave bus
);

    if ((ROUNDS < 1) || (ROUNDS > 12)) begin : g_rounds_check
        $error("xoodoo_perm: ROUNDS must be in the range 1..12");
    end

    // First schedule index used, and the round counter value of the final round.
    localparam logic [3:0] FIRST_IDX = 4'(12 - ROUNDS);
    localparam logic [3:0] LAST_RC   = 4'(ROUNDS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    fsm_t         state_r;
    fsm_t         next_state_s;
    logic [3:0]   rc_r;
    logic [383:0] work_r;
    logic         complete_r;
    logic         busy_r;
    logic         load_s;
    logic         last_s;
    logic [383:0] round_s;

    // Rotate each 32-bit lane of a plane left by n bits (0 < n < 32).
    function automatic logic [127:0] rotl_lanes(input logic [127:0] v, input int n);
        logic [127:0] r;
        r = 128'd0;
        for (int x = 0; x < 4; x++) begin
            r[x*32 +: 32] = (v[x*32 +: 32] << n) | (v[x*32 +: 32] >> (32 - n));
        end
        return r;
    endfunction

    // Round constant for a position in the 12-round schedule.
    function automatic logic [31:0] round_const(input logic [3:0] idx);
        logic [31:0] c;
        case (idx)
            4'd0:    c = 32'h0000_0058;
            4'd1:    c = 32'h0000_0038;
            4'd2:    c = 32'h0000_03C0;
            4'd3:    c = 32'h0000_00D0;
            4'd4:    c = 32'h0000_0120;
            4'd5:    c = 32'h0000_0014;
            4'd6:    c = 32'h0000_0060;
            4'd7:    c = 32'h0000_002C;
            4'd8:    c = 32'h0000_0380;
            4'd9:    c = 32'h0000_00F0;
            4'd10:   c = 32'h0000_01A0;
            4'd11:   c = 32'h0000_0012;
            default: c = 32'h0000_0000;
        endcase
        return c;
    endfunction

    // One complete Xoodoo round: theta, rho-west, iota, chi, rho-east.
    function automatic logic [383:0] xoodoo_round(input logic [383:0] s, input logic [31:0] c);
        logic [127:0] a0, a1, a2, p, ps, e, b0, b1, b2;
        a0 = s[127:0];
        a1 = s[255:128];
        a2 = s[383:256];
        // theta: lane x receives column parity of lane x-1
        p  = a0 ^ a1 ^ a2;
        ps = {p[95:0], p[127:96]};
        e  = rotl_lanes(ps, 5) ^ rotl_lanes(ps, 14);
        a0 = a0 ^ e;
        a1 = a1 ^ e;
        a2 = a2 ^ e;
        // rho-west
        a1 = {a1[95:0], a1[127:96]};
        a2 = rotl_lanes(a2, 11);
        // iota
        a0[31:0] = a0[31:0] ^ c;
        // chi
        b0 = ~a1 & a2;
        b1 = ~a2 & a0;
        b2 = ~a0 & a1;
        a0 = a0 ^ b0;
        a1 = a1 ^ b1;
        a2 = a2 ^ b2;
        // rho-east: lane x of plane 2 comes from lane x+2
        a1 = rotl_lanes(a1, 1);
        a2 = rotl_lanes({a2[63:0], a2[127:64]}, 8);
        return {a2, a1, a0};
    endfunction

    assign round_s = xoodoo_round(work_r, round_const(FIRST_IDX + rc_r));

    // Next-state decode: accept a start only when idle, finish after the last round.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.enable) begin
                    next_state_s = RUN;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (rc_r == LAST_RC) begin
                    next_state_s = IDLE;
                    last_s       = 1'b1;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM, round counter, working register and status flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            rc_r       <= 4'd0;
            work_r     <= 384'd0;
            complete_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            complete_r <= last_s;
            busy_r     <= (next_state_s == RUN);
            if (load_s) begin
                work_r <= bus.state_in;
                rc_r   <= 4'd0;
            end else if (state_r == RUN) begin
                work_r <= round_s;
                rc_r   <= last_s ? 4'd0 : (rc_r + 4'd1);
            end
        end
    end

    assign bus.state_out = work_r;
    assign bus.complete  = complete_r;
    assign bus.busy      = busy_r;

endmodule

// File: doc/xoodoo_perm.md
# xoodoo_perm

Iterative Xoodoo[n] permutation core on the 384-bit Xoodoo state, one round per clock. It sits directly downstream of the Xoodyak hash controller. The controller pulses `enable` with the current state on `state_in`; this block runs the rounds and returns the permuted state on `state_out` with a one-cycle `complete` pulse. The controller latches `state_out` on that pulse.

## Interface
- `ROUNDS`, default 12: number of rounds, legal range 1..12. Runs the last `ROUNDS` constants of the 12-round schedule, so `ROUNDS=12` is Xoodoo[12].
- `clk`  in  1: clock; all state changes on the rising edge.
- `resetn`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: start request, sampled at the clock edge. Only acted on when the block is idle.
- `state_in`  in  384: state to permute, captured when `enable` is accepted.
- `state_out`  out  384: working and result register.
- `complete`  out  1: one-cycle pulse; `state_out` holds the finished result.
- `busy`  out  1: high while rounds are in progress.

## Operation
- State layout:
  - Lane `A[y][x]` = `state[(4*y+x)*32 +: 32]`, with y = plane 0..2 and x = 0..3.
  - Little-endian bytes, so byte k = `state[8k+7:8k]`.
- FSM with two states, IDLE and RUN.
  - IDLE with `enable`=1: load `state_in` into the working register, clear the round counter `rc` to 0, go to RUN.
  - RUN: apply one round per cycle using constant `C[12-ROUNDS+rc]`, then increment `rc`.
  - After the round with `rc`=ROUNDS-1, return to IDLE and assert `complete` for one cycle.
- One round, all lane indices x mod 4, all rotations 32-bit left rotates:
  - theta: `P[x]` = `A0[x]^A1[x]^A2[x]`; `E[x]` = `rotl(P[x-1],5)^rotl(P[x-1],14)`; every lane `Ay[x] ^= E[x]`.
  - rho-west: `A1[x]` ← `A1[x-1]`; `A2[x]` ← `rotl(A2[x],11)`.
  - iota: `A0[0] ^= C`.
  - chi: `B0`=`~A1&A2`, `B1`=`~A2&A0`, `B2`=`~A0&A1`; then `Ay ^= By`.
  - rho-east: `A1[x]` ← `rotl(A1[x],1)`; `A2[x]` ← `rotl(A2[x+2],8)`.
- Round constants `C[0..11]`, zero-extended to 32 bits: 0x058, 0x038, 0x3C0, 0x0D0, 0x120, 0x014, 0x060, 0x02C, 0x380, 0x0F0, 0x1A0, 0x012.
- Round logic is combinational between working-register reads and writes; there is no pipelining inside a round.
- `enable` in RUN is ignored. It is neither queued nor allowed to restart the run.
- `state_out` is the working register itself. It shows intermediate rounds while `busy`=1. It is stable from the `complete` cycle until the next accepted `enable`.
- Illegal `ROUNDS` values are an elaboration-time error.

## Timing
- Reset values: `state_out`=0, `complete`=0, `busy`=0, FSM in IDLE, `rc`=0.
- Assertion of `resetn` is asynchronous; release is synchronous to `clk`.
- Edge E0, `enable`=1 in IDLE: `state_out`=`state_in` and `busy`=1 after E0.
- Edges E1..E(ROUNDS): one round each.
  - After E(ROUNDS): `busy`=0 and `complete`=1.
  - After E(ROUNDS+1): `complete`=0, unless a new run has finished.
- Latency from `enable` sample to `complete` high is ROUNDS+1 edges: 13 for Xoodoo[12]. This fits inside the controller's 23-cycle permutation window.
- Back-to-back runs: `enable`=1 in the `complete` cycle is accepted, because the FSM is already IDLE. The new `state_in` is loaded on that edge, `complete` drops, and `busy` rises.
- Reset mid-RUN: the run is abandoned immediately and all outputs return to reset values. No `complete` is issued for that run.
- `enable` held high continuously: a new run is started each time the FSM is IDLE, so runs are back-to-back.

## Test plan
- Reset, then idle: check that `state_out`=0, `complete`=0 and `busy`=0 for 20 cycles with `enable` low.
- `ROUNDS`=1, `state_in`=0, one `enable` pulse:
  - `complete` is high exactly 2 edges after the `enable` sample.
  - `state_out[31:0]`=0x00000012 and `state_out[159:128]`=0x00000024.
  - All other bits are 0.
- `ROUNDS`=12, `state_in`=0 and then 50 random states:
  - `state_out` at `complete` matches the software Xoodoo[12] model bit for bit.
  - `complete` arrives 13 edges after each `enable`.
  - `busy` is high for exactly 12 cycles.
- `enable` pulses during RUN on rounds 3 and 11: the result is unchanged versus the undisturbed run, and no extra `complete` occurs.
- `enable` held high for 3 runs with a different `state_in` presented at each accept edge:
  - Three `complete` pulses, 13 edges apart.
  - Each result matches the model for its own input.
- `resetn` asserted for 1 cycle at round 6, then a fresh run:
  - Outputs are 0 immediately and no stale `complete` is seen.
  - The fresh run's result matches the model.
